// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Signal bundle between the decode stage and the hazard,
//                forwarding and interrupt controller.
//                master : decode side, drives decoded fields and events,
//                         receives operand selects, stall/flush and IRQ state.
//                slave  : the controller itself.
//                Decode -> controller : issue_valid, rs1, rs2, rd, rd_we,
//                                       is_load, pc_in, jump_taken, iret,
//                                       interrupt
//                Controller -> decode : fwd_sel_a, fwd_sel_b, stall, flush,
//                                       irq_take, irq_vec, epc, irq_en
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int ADDR_W = 16,
    parameter int SEL_W  = 2
);
    logic              issue_valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic              is_load;
    logic [ADDR_W-1:0] pc_in;
    logic              jump_taken;
    logic              iret;
    logic              interrupt;

    logic [SEL_W-1:0]  fwd_sel_a;
    logic [SEL_W-1:0]  fwd_sel_b;
    logic              stall;
    logic              flush;
    logic              irq_take;
    logic [ADDR_W-1:0] irq_vec;
    logic [ADDR_W-1:0] epc;
    logic              irq_en;

    modport master (
        output issue_valid, rs1, rs2, rd, rd_we, is_load, pc_in,
               jump_taken, iret, interrupt,
        input  fwd_sel_a, fwd_sel_b, stall, flush, irq_take,
               irq_vec, epc, irq_en
    );

    modport slave (
        input  issue_valid, rs1, rs2, rd, rd_we, is_load, pc_in,
               jump_taken, iret, interrupt,
        output fwd_sel_a, fwd_sel_b, stall, flush, irq_take,
               irq_vec, epc, irq_en
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Hazard, forwarding and precise-interrupt controller that
//                sits beside the decode stage of the pipelined MIPS core.
//                A DEPTH-entry scoreboard tracks the destination of every
//                instruction in the downstream stages (1 = EX, 2 = DM,
//                3 = WB for the default depth). From it the controller
//                derives per-operand forwarding selects, load-use stalls,
//                and together with jump resolution and the edge-detected
//                external interrupt, the decode flush and interrupt take.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                bus (slave)       - decoded fields in; selects, stall,
//                                    flush, irq_take, irq_vec, epc,
//                                    irq_en out
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int                REG_AW     = 5,
    parameter int                ADDR_W     = 16,
    parameter int                DEPTH      = 3,
    parameter int                LOAD_STAGE = 2,
    parameter logic [ADDR_W-1:0] IRQ_VEC    = 16'h0040,
    parameter int                SEL_W      = $clog2(DEPTH + 1)
) (
    input  wire logic         clk,
    input  wire logic         reset,
    pipe_hazard_ctrl_if.slave bus
);

    // ------------------------------------------------------------------
    // Scoreboard. Index k holds stage k+1; index 0 is the youngest (EX).
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]             r_sb_valid;
    logic [DEPTH-1:0]             r_sb_we;
    logic [DEPTH-1:0]             r_sb_load;
    logic [DEPTH-1:0][REG_AW-1:0] r_sb_rd;

    // Interrupt state
    logic              r_int_hist;
    logic              r_irq_pending;
    logic [ADDR_W-1:0] r_epc;
    logic              r_irq_en;

    // Combinational decisions
    logic [1:0][REG_AW-1:0] w_rs;
    logic [1:0][SEL_W-1:0]  w_sel;
    logic [1:0]             w_load_hazard;
    logic                   w_stall;
    logic                   w_irq_take;
    logic                   w_flush;
    logic                   w_accept;
    logic                   w_int_edge;

    assign w_rs[0] = bus.rs1;
    assign w_rs[1] = bus.rs2;

    // ------------------------------------------------------------------
    // Per-operand producer search. Scanning from the oldest stage down to
    // the youngest lets the last hit win, so the youngest producer is
    // selected when several in-flight instructions target the same rd.
    // The load/early flags travel with the hit so the stall decision
    // refers to exactly the entry being forwarded from.
    // ------------------------------------------------------------------
    for (genvar op = 0; op < 2; op++) begin : g_operand
        logic [SEL_W-1:0] w_sel_op;
        logic             w_hit_load;
        logic             w_hit_early;

        always_comb begin
            w_sel_op    = '0;
            w_hit_load  = 1'b0;
            w_hit_early = 1'b0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (r_sb_valid[k] && r_sb_we[k] &&
                    (r_sb_rd[k] == w_rs[op]) && (w_rs[op] != '0)) begin
                    w_sel_op    = SEL_W'(k + 1);
                    w_hit_load  = r_sb_load[k];
                    // Load data only exists from LOAD_STAGE onwards.
                    w_hit_early = ((k + 1) < LOAD_STAGE);
                end
            end
        end

        assign w_sel[op]         = w_sel_op;
        assign w_load_hazard[op] = w_hit_load & w_hit_early;
    end

    // ------------------------------------------------------------------
    // Stall / interrupt / flush decisions
    // ------------------------------------------------------------------
    assign w_stall    = bus.issue_valid & (|w_load_hazard);

    // A taken jump owns this cycle; a pending interrupt waits for the next
    // eligible instruction so the saved PC is always a real instruction.
    assign w_irq_take = r_irq_pending & r_irq_en & bus.issue_valid &
                        ~w_stall & ~bus.jump_taken;

    assign w_flush    = bus.jump_taken | w_irq_take;

    // Only a decoded, non-stalled, non-flushed instruction proceeds.
    assign w_accept   = bus.issue_valid & ~w_stall & ~w_flush;

    assign w_int_edge = bus.interrupt & ~r_int_hist;

    // ------------------------------------------------------------------
    // Scoreboard shift. The downstream pipe never stalls, so entries
    // advance every cycle and the oldest falls off the end.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sb_valid <= '0;
            r_sb_we    <= '0;
            r_sb_load  <= '0;
            r_sb_rd    <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_sb_valid[k] <= r_sb_valid[k-1];
                r_sb_we[k]    <= r_sb_we[k-1];
                r_sb_load[k]  <= r_sb_load[k-1];
                r_sb_rd[k]    <= r_sb_rd[k-1];
            end
            r_sb_valid[0] <= w_accept;
            // Writes to r0 are discarded so they never create a hazard.
            r_sb_we[0]    <= w_accept & bus.rd_we & (bus.rd != '0);
            r_sb_load[0]  <= w_accept & bus.is_load;
            r_sb_rd[0]    <= bus.rd;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt edge detect, pending latch, EPC and enable
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_int_hist    <= 1'b0;
            r_irq_pending <= 1'b0;
            r_epc         <= '0;
            r_irq_en      <= 1'b1;
        end else begin
            r_int_hist <= bus.interrupt;

            // No queueing: further edges while pending are absorbed, and
            // a take always clears the single pending request.
            if (w_irq_take) begin
                r_irq_pending <= 1'b0;
            end else if (w_int_edge) begin
                r_irq_pending <= 1'b1;
            end

            if (w_irq_take) begin
                r_epc    <= bus.pc_in;
                r_irq_en <= 1'b0;
            end else if (bus.iret && w_accept) begin
                r_irq_en <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.fwd_sel_a = w_sel[0];
    assign bus.fwd_sel_b = w_sel[1];
    assign bus.stall     = w_stall;
    assign bus.flush     = w_flush;
    assign bus.irq_take  = w_irq_take;
    assign bus.irq_vec   = IRQ_VEC;
    assign bus.epc       = r_epc;
    assign bus.irq_en    = r_irq_en;

endmodule
`default_nettype wire
